sobel_4dir_conv: RTL

SOBEL_4DIR_CONV -- requirements
Module: sobel_4dir_conv

---
 rtl/sobel_pkg.sv | 30 +++
 rtl/sobel_kernel_mac.sv | 26 ++
 rtl/sobel_4dir_conv.sv | 85 ++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths and kernel coefficient tables for the 4-direction Sobel block
package sobel_pkg;
    localparam int PIX_W          = 8;
    localparam int GRAD_W         = 11;
    localparam int SUM_W          = 12;
    localparam int LINE_WIDTH_DEF = 512;
    localparam int COEF_W         = 3;
    localparam int TAPS           = 9;
    localparam int ABS_W          = GRAD_W - 1;

    // Coefficients listed row-major (k = row*3 + col); tap k lands at bits [3k+2:3k].
    function automatic logic [TAPS*COEF_W-1:0] kern(input int c0, input int c1, input int c2,
                                                    input int c3, input int c4, input int c5,
                                                    input int c6, input int c7, input int c8);
        kern = {COEF_W'(c8), COEF_W'(c7), COEF_W'(c6), COEF_W'(c5), COEF_W'(c4),
                COEF_W'(c3), COEF_W'(c2), COEF_W'(c1), COEF_W'(c0)};
    endfunction

    localparam logic [TAPS*COEF_W-1:0] KERN_GX   = kern(-1, 0, 1, -2, 0, 2, -1, 0, 1);
    localparam logic [TAPS*COEF_W-1:0] KERN_GY   = kern(-1, -2, -1, 0, 0, 0, 1, 2, 1);
    localparam logic [TAPS*COEF_W-1:0] KERN_G45  = kern(0, 1, 2, -1, 0, 1, -2, -1, 0);
    localparam logic [TAPS*COEF_W-1:0] KERN_G135 = kern(-2, -1, 0, -1, 0, 1, 0, 1, 2);

    // Gradients never reach -1024, so the magnitude always fits in GRAD_W-1 bits.
    function automatic logic [ABS_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] n;
        n = g[GRAD_W-1] ? -g : g;
        return n[ABS_W-1:0];
    endfunction
endpackage

// File: rtl/sobel_kernel_mac.sv
// rtl/sobel_kernel_mac.sv - 3x3 window times signed coefficient table, one GRAD_W gradient
module sobel_kernel_mac
    import sobel_pkg::*;
(
    input  logic [TAPS*PIX_W-1:0]  i_window,
    input  logic [TAPS*COEF_W-1:0] i_coef,
    output logic [GRAD_W-1:0]      o_grad
);
    logic signed [GRAD_W-1:0] acc;
    logic signed [GRAD_W-1:0] pix;
    logic signed [GRAD_W-1:0] coef;

    // Modular GRAD_W arithmetic is exact because the final sum stays within +/-1020.
    always_comb begin
        acc  = '0;
        pix  = '0;
        coef = '0;
        for (int k = 0; k < TAPS; k++) begin
            pix  = {{(GRAD_W-PIX_W){1'b0}}, i_window[k*PIX_W +: PIX_W]};
            coef = {{(GRAD_W-COEF_W){i_coef[k*COEF_W+COEF_W-1]}}, i_coef[k*COEF_W +: COEF_W]};
            acc  = acc + pix * coef;
        end
    end

    assign o_grad = acc;
endmodule

// File: rtl/sobel_4dir_conv.sv
// rtl/sobel_4dir_conv.sv - 3-stage 4-direction Sobel edge magnitude with line-done pulse
// Define SOBEL_THRESHOLD_EN to binarise the output against THRESHOLD.
module sobel_4dir_conv
    import sobel_pkg::*;
#(
    parameter int          LINE_WIDTH = LINE_WIDTH_DEF,
    parameter logic [7:0]  THRESHOLD  = 8'd100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [71:0] i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [7:0]  o_convolved_data,
    output logic        o_convolved_data_valid,
    output logic        o_line_done
);
    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);

    logic [GRAD_W-1:0] gx_d, gy_d, g45_d, g135_d;
    logic [GRAD_W-1:0] gx_q, gy_q, g45_q, g135_q;
    logic [ABS_W-1:0]  ax_q, ay_q, a45_q, a135_q;
    logic              v1_q, v2_q, v3_q;
    logic [PIX_W-1:0]  data_q, data_d, mag_d;
    logic              done_q;
    logic [CW-1:0]     col_q;
    logic [SUM_W-1:0]  sum_d, scaled_d;

    sobel_kernel_mac u_mac_gx   (.i_window(i_pixel_data), .i_coef(KERN_GX),   .o_grad(gx_d));
    sobel_kernel_mac u_mac_gy   (.i_window(i_pixel_data), .i_coef(KERN_GY),   .o_grad(gy_d));
    sobel_kernel_mac u_mac_g45  (.i_window(i_pixel_data), .i_coef(KERN_G45),  .o_grad(g45_d));
    sobel_kernel_mac u_mac_g135 (.i_window(i_pixel_data), .i_coef(KERN_G135), .o_grad(g135_d));

    assign sum_d    = SUM_W'(ax_q) + SUM_W'(ay_q) + SUM_W'(a45_q) + SUM_W'(a135_q);
    assign scaled_d = sum_d >> 2;
    assign mag_d    = (|scaled_d[SUM_W-1:PIX_W]) ? '1 : scaled_d[PIX_W-1:0];

`ifdef SOBEL_THRESHOLD_EN
    assign data_d = (mag_d >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    logic [7:0] unused_threshold;
    assign unused_threshold = THRESHOLD;
    assign data_d = mag_d;
`endif

    // Data stages carry no reset: the valid chain alone decides what reaches the output.
    always_ff @(posedge i_clk) begin
        if (i_pixel_data_valid) begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            g45_q  <= g45_d;
            g135_q <= g135_d;
        end
        if (v1_q) begin
            ax_q   <= grad_abs(gx_q);
            ay_q   <= grad_abs(gy_q);
            a45_q  <= grad_abs(g45_q);
            a135_q <= grad_abs(g135_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
            col_q  <= '0;
        end else begin
            v1_q   <= i_pixel_data_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            done_q <= v2_q && (col_q == COL_LAST);
            if (v2_q) begin
                data_q <= data_d;
                col_q  <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            end
        end
    end

    assign o_convolved_data       = data_q;
    assign o_convolved_data_valid = v3_q;
    assign o_line_done            = done_q;
endmodule
